// File: rtl/washer_ctrl_param_if.sv
`default_nettype none
// ============================================================================
// Module      : washer_ctrl_param_if
// Description : Panel-side bundle for the washer sequencer. Groups the
//               time-base strobe, the debounced panel inputs and the
//               LED/lock/buzzer/remaining-time outputs.
//               master : panel/driver side (drives inputs, reads outputs)
//               slave  : sequencer side (reads inputs, drives outputs)
// Ports       : tick, start_stop, cycle_select, door_open (to sequencer)
//               led_cycle[1:0], led_state[3:0], door_lock, buzzer,
//               remaining[TW-1:0] (from sequencer)
// Revision    : 1.0 - initial release
// ============================================================================
interface washer_ctrl_param_if #(
   parameter int TW = 8
);
   logic          tick;
   logic          start_stop;
   logic          cycle_select;
   logic          door_open;
   logic [1:0]    led_cycle;
   logic [3:0]    led_state;
   logic          door_lock;
   logic          buzzer;
   logic [TW-1:0] remaining;

   modport master (
      output tick, start_stop, cycle_select, door_open,
      input  led_cycle, led_state, door_lock, buzzer, remaining
   );

   modport slave (
      input  tick, start_stop, cycle_select, door_open,
      output led_cycle, led_state, door_lock, buzzer, remaining
   );
endinterface
`default_nettype wire

// File: rtl/washer_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : washer_ctrl_param
// Description : Washing-machine sequencer with tick time base, cycle-scaled
//               phase durations, RINSES rinse/drain passes, pause/resume that
//               keeps phase and remaining time, abort-to-drain and a timed
//               buzzer. Optional PREWASH phase enabled by macro WM_PREWASH_EN.
// Ports       : clk      - system clock, rising edge
//               reset_n  - asynchronous active-low reset
//               bus      - washer_ctrl_param_if.slave (panel inputs, LED /
//                          lock / buzzer / remaining-time outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module washer_ctrl_param #(
   parameter int TW         = 8,
   parameter int RINSES     = 2,
   parameter int FILL_T     = 5,
   parameter int WASH_T     = 10,
   parameter int DRAIN_T    = 3,
   parameter int RINSE_T    = 5,
   parameter int SPIN_T     = 8,
   parameter int PREWASH_T  = 4,
   parameter int BUZZ_TICKS = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   washer_ctrl_param_if.slave   bus
);

   localparam logic [3:0] c_st_idle     = 4'd0;
   localparam logic [3:0] c_st_prewash  = 4'd1;
   localparam logic [3:0] c_st_fill     = 4'd2;
   localparam logic [3:0] c_st_wash     = 4'd3;
   localparam logic [3:0] c_st_drain    = 4'd4;
   localparam logic [3:0] c_st_rinse    = 4'd5;
   localparam logic [3:0] c_st_spin     = 4'd6;
   localparam logic [3:0] c_st_paused   = 4'd7;
   localparam logic [3:0] c_st_complete = 4'd8;

   localparam logic [TW-1:0] c_rem_one   = TW'(1);
   localparam logic [TW-1:0] c_buzz_load = TW'(BUZZ_TICKS);

   // Duration = base * (cycle + 1), saturated to the timer width, never 0.
   function automatic logic [TW-1:0] phase_dur(input logic [3:0] st, input logic [1:0] cyc);
      longint base;
      longint prod;
      longint lim;
      case (st)
         c_st_prewash: base = longint'(PREWASH_T);
         c_st_fill:    base = longint'(FILL_T);
         c_st_wash:    base = longint'(WASH_T);
         c_st_drain:   base = longint'(DRAIN_T);
         c_st_rinse:   base = longint'(RINSE_T);
         c_st_spin:    base = longint'(SPIN_T);
         default:      base = 0;
      endcase
      prod = base * (longint'(cyc) + 1);
      lim  = (longint'(1) << TW) - 1;
      if (prod > lim) prod = lim;
      if (prod < 1)   prod = 1;
      return prod[TW-1:0];
   endfunction

   function automatic logic is_active(input logic [3:0] st);
      return (st >= c_st_prewash) && (st <= c_st_spin);
   endfunction

   logic          r_ss_q, r_cs_q, r_edge_en;
   logic          w_ss_edge, w_cs_edge;
   logic [3:0]    r_state, w_state;
   logic [3:0]    r_saved, w_saved;
   logic [TW-1:0] r_remaining, w_remaining;
   logic [1:0]    r_cycle, w_cycle;
   logic          r_abort, w_abort;
   logic [2:0]    r_rinse_cnt, w_rinse_cnt;
   logic [TW-1:0] r_buzz_cnt, w_buzz_cnt;
   logic          r_door_lock, r_buzzer;

   // r_edge_en stays low for the first cycle after reset so a button held
   // through reset is absorbed into the history register, not seen as a press.
   assign w_ss_edge = bus.start_stop   & ~r_ss_q & r_edge_en;
   assign w_cs_edge = bus.cycle_select & ~r_cs_q & r_edge_en;

   always_comb begin
      w_state     = r_state;
      w_saved     = r_saved;
      w_remaining = r_remaining;
      w_cycle     = r_cycle;
      w_abort     = r_abort;
      w_rinse_cnt = r_rinse_cnt;
      w_buzz_cnt  = r_buzz_cnt;

      case (r_state)
         c_st_idle: begin
            w_remaining = '0;
            if (w_ss_edge && !bus.door_open) begin
               w_rinse_cnt = '0;
               w_abort     = 1'b0;
`ifdef WM_PREWASH_EN
               w_state     = c_st_prewash;
`else
               w_state     = c_st_fill;
`endif
               w_remaining = phase_dur(w_state, r_cycle);
            end else if (w_cs_edge) begin
               w_cycle = (r_cycle == 2'd2) ? 2'd0 : r_cycle + 2'd1;
            end
         end

         c_st_prewash, c_st_fill, c_st_wash, c_st_drain, c_st_rinse, c_st_spin: begin
            // Pause requests take priority; a tick in the same cycle is dropped.
            if (w_ss_edge || bus.door_open) begin
               w_state = c_st_paused;
               w_saved = r_state;
            end else if (bus.tick) begin
               if (r_remaining > c_rem_one) begin
                  w_remaining = r_remaining - c_rem_one;
               end else begin
                  case (r_state)
                     c_st_prewash: w_state = c_st_fill;
                     c_st_fill:    w_state = c_st_wash;
                     c_st_wash:    w_state = c_st_drain;
                     c_st_rinse:   w_state = c_st_drain;
                     c_st_drain: begin
                        // The rinse counter separates the first drain from
                        // the post-rinse drains; an aborted run ends here.
                        if (r_abort) begin
                           w_state = c_st_complete;
                        end else if (int'(r_rinse_cnt) < RINSES) begin
                           w_state     = c_st_rinse;
                           w_rinse_cnt = r_rinse_cnt + 3'd1;
                        end else begin
                           w_state = c_st_spin;
                        end
                     end
                     default:      w_state = c_st_complete;
                  endcase
                  w_remaining = (w_state == c_st_complete) ? '0 : phase_dur(w_state, r_cycle);
               end
            end
         end

         c_st_paused: begin
            // Remaining is frozen here and doubles as the saved remaining time.
            if (w_cs_edge) begin
               w_state     = c_st_drain;
               w_remaining = phase_dur(c_st_drain, r_cycle);
               w_abort     = 1'b1;
            end else if (w_ss_edge && !bus.door_open) begin
               w_state = r_saved;
            end
         end

         c_st_complete: begin
            w_remaining = '0;
            if (w_ss_edge) begin
               w_state = c_st_idle;
               w_abort = 1'b0;
            end
         end

         default: begin
            w_state     = c_st_idle;
            w_remaining = '0;
         end
      endcase

      // Buzzer restarts on entry to PAUSED/COMPLETE, any other change silences it.
      if (w_state != r_state) begin
         w_buzz_cnt = ((w_state == c_st_paused) || (w_state == c_st_complete)) ? c_buzz_load : '0;
      end else if (bus.tick && (r_buzz_cnt != '0)) begin
         w_buzz_cnt = r_buzz_cnt - c_rem_one;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ss_q      <= 1'b0;
         r_cs_q      <= 1'b0;
         r_edge_en   <= 1'b0;
         r_state     <= c_st_idle;
         r_saved     <= c_st_idle;
         r_remaining <= '0;
         r_cycle     <= 2'd0;
         r_abort     <= 1'b0;
         r_rinse_cnt <= 3'd0;
         r_buzz_cnt  <= '0;
         r_door_lock <= 1'b0;
         r_buzzer    <= 1'b0;
      end else begin
         r_ss_q      <= bus.start_stop;
         r_cs_q      <= bus.cycle_select;
         r_edge_en   <= 1'b1;
         r_state     <= w_state;
         r_saved     <= w_saved;
         r_remaining <= w_remaining;
         r_cycle     <= w_cycle;
         r_abort     <= w_abort;
         r_rinse_cnt <= w_rinse_cnt;
         r_buzz_cnt  <= w_buzz_cnt;
         r_door_lock <= is_active(w_state);
         r_buzzer    <= (w_buzz_cnt != '0);
      end
   end

   assign bus.led_cycle = r_cycle;
   assign bus.led_state = r_state;
   assign bus.remaining = r_remaining;
   assign bus.door_lock = r_door_lock;
   assign bus.buzzer    = r_buzzer;

endmodule
`default_nettype wire
